monkey_collision_detector: RTL and testbench

//  Per-frame collision detector that feeds the monkey movement stage.
//  - Compares the monkey drawing request with the wall and ladder drawing requests pixel by pixel during the VGA scan.
//  - Classifies each overlap pixel by which edge of the monkey sprite it lies on.
//  - Accumulates those classifications over one frame.
//  - Presents the result as a single-cycle collision pulse plus a held 4-bit HitEdgeCode.

---
 rtl/monkey_collision_detector.sv | 100 ++++++++++
 tb/tb_monkey_collision_detector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/monkey_collision_detector.sv
// rtl/monkey_collision_detector.sv - per-frame monkey vs wall/ladder collision detector with edge classification
module monkey_collision_detector #(
    parameter int OBJECT_WIDTH  = 64,
    parameter int OBJECT_HEIGHT = 64,
    parameter int EDGE_MARGIN   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [10:0] monkeyTopLeftX,
    input  logic [10:0] monkeyTopLeftY,
    input  logic        monkeyDR,
    input  logic        wallDR,
    input  logic        ladderDR,
    output logic        wallCollision,
    output logic        ladderCollision,
    output logic [3:0]  HitEdgeCode
);

    localparam logic signed [11:0] MARGIN_LO = 12'(EDGE_MARGIN);
    localparam logic signed [11:0] RIGHT_LO  = 12'(OBJECT_WIDTH - EDGE_MARGIN);
    localparam logic signed [11:0] BOTTOM_LO = 12'(OBJECT_HEIGHT - EDGE_MARGIN);

    // Pixel offsets relative to the sprite; top-left is signed so the sprite may hang off-screen.
    logic signed [11:0] off_x;
    logic signed [11:0] off_y;
    logic [3:0]         edge_code;

    assign off_x = $signed({1'b0, pixelX}) - $signed({monkeyTopLeftX[10], monkeyTopLeftX});
    assign off_y = $signed({1'b0, pixelY}) - $signed({monkeyTopLeftY[10], monkeyTopLeftY});

    // Edge bands: [3]=left [2]=top [1]=right [0]=bottom; out-of-box offsets fall into the nearest band.
    always_comb begin
        edge_code    = 4'b0000;
        edge_code[3] = (off_x <  MARGIN_LO);
        edge_code[2] = (off_y <  MARGIN_LO);
        edge_code[1] = (off_x >= RIGHT_LO);
        edge_code[0] = (off_y >= BOTTOM_LO);
    end

    logic       s1_wall;
    logic       s1_ladder;
    logic [3:0] s1_code;

    // Stage 1: register the overlap flags and the edge classification of the current pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_wall   <= 1'b0;
            s1_ladder <= 1'b0;
            s1_code   <= 4'b0000;
        end else begin
            s1_wall   <= monkeyDR & wallDR;
            s1_ladder <= monkeyDR & ladderDR;
            s1_code   <= edge_code;
        end
    end

    logic       acc_wall;
    logic       acc_ladder;
    logic [3:0] acc_code;

    // Frame totals including the stage-1 pixel still in flight; only wall overlaps shape the code.
    logic       snap_wall;
    logic       snap_ladder;
    logic [3:0] snap_code;

    assign snap_wall   = acc_wall | s1_wall;
    assign snap_ladder = acc_ladder | s1_ladder;
    assign snap_code   = acc_code | (s1_wall ? s1_code : 4'b0000);

    // Stage 2: accumulate over the frame, report and restart at each frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_wall        <= 1'b0;
            acc_ladder      <= 1'b0;
            acc_code        <= 4'b0000;
            wallCollision   <= 1'b0;
            ladderCollision <= 1'b0;
            HitEdgeCode     <= 4'b0000;
        end else if (startOfFrame) begin
            acc_wall        <= 1'b0;
            acc_ladder      <= 1'b0;
            acc_code        <= 4'b0000;
            wallCollision   <= snap_wall;
            ladderCollision <= snap_ladder;
            if (snap_wall) begin
                HitEdgeCode <= snap_code;
            end
        end else begin
            acc_wall        <= snap_wall;
            acc_ladder      <= snap_ladder;
            acc_code        <= snap_code;
            wallCollision   <= 1'b0;
            ladderCollision <= 1'b0;
        end
    end

endmodule

// File: tb/tb_monkey_collision_detector.sv
// tb/tb_monkey_collision_detector.sv - randomized self-checking bench for monkey_collision_detector
module tb_monkey_collision_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] monkeyTopLeftX;
    logic [10:0] monkeyTopLeftY;
    logic        monkeyDR;
    logic        wallDR;
    logic        ladderDR;
    logic        wallCollision;
    logic        ladderCollision;
    logic [3:0]  HitEdgeCode;

    int checks   = 0;
    int failures = 0;

    // Reference model: the frame is a set of overlap facts, reported when the next frame starts.
    bit frame_wall;
    bit frame_ladder;
    int frame_code;
    int exp_wc;
    int exp_lc;
    int exp_code;

    monkey_collision_detector dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .monkeyTopLeftX (monkeyTopLeftX),
        .monkeyTopLeftY (monkeyTopLeftY),
        .monkeyDR       (monkeyDR),
        .wallDR         (wallDR),
        .ladderDR       (ladderDR),
        .wallCollision  (wallCollision),
        .ladderCollision(ladderCollision),
        .HitEdgeCode    (HitEdgeCode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int edges(input int px, input int py, input int tlx, input int tly);
        int ox;
        int oy;
        int c;
        ox = px - tlx;
        oy = py - tly;
        c = 0;
        if (ox < 4)  c += 8;
        if (oy < 4)  c += 4;
        if (ox >= 60) c += 2;
        if (oy >= 60) c += 1;
        return c;
    endfunction

    // One clock: present inputs, advance the model, then compare just after the edge.
    task automatic step(input bit rst, input bit sof, input int px, input int py,
                        input int tlx, input int tly, input bit mdr, input bit wdr, input bit ldr);
        reset          = rst;
        startOfFrame   = sof;
        pixelX         = 11'(px);
        pixelY         = 11'(py);
        monkeyTopLeftX = 11'(tlx);
        monkeyTopLeftY = 11'(tly);
        monkeyDR       = mdr;
        wallDR         = wdr;
        ladderDR       = ldr;
        if (rst) begin
            frame_wall = 0; frame_ladder = 0; frame_code = 0;
            exp_wc = 0; exp_lc = 0; exp_code = 0;
        end else begin
            exp_wc = 0; exp_lc = 0;
            if (sof) begin
                exp_wc = int'(frame_wall);
                exp_lc = int'(frame_ladder);
                if (frame_wall) exp_code = frame_code;
                frame_wall = 0; frame_ladder = 0; frame_code = 0;
            end
            if (mdr && wdr) begin
                frame_wall = 1;
                frame_code = frame_code | edges(px, py, tlx, tly);
            end
            if (mdr && ldr) frame_ladder = 1;
        end
        @(posedge clk);
        #1;
        check("wallCollision", int'(wallCollision), exp_wc);
        check("ladderCollision", int'(ladderCollision), exp_lc);
        check("HitEdgeCode", int'(HitEdgeCode), exp_code);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 10, 10, 280, 185, 0, 0, 0);
    endtask

    task automatic wall_px(input bit sof, input int px, input int py);
        step(0, sof, px, py, 280, 185, 1, 1, 0);
    endtask

    task automatic sof_only();
        step(0, 1, 10, 10, 280, 185, 0, 0, 0);
    endtask

    initial begin
        frame_wall = 0; frame_ladder = 0; frame_code = 0;
        exp_wc = 0; exp_lc = 0; exp_code = 0;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_wc", int'(wallCollision), 0);
        check("rst_lc", int'(ladderCollision), 0);
        check("rst_code", int'(HitEdgeCode), 0);
        idle(2);
        sof_only();

        // Floor hit, presented the cycle before the boundary.
        idle(3);
        wall_px(0, 300, 248);
        sof_only();
        check("floor_pulse", int'(wallCollision), 1);
        check("floor_code", int'(HitEdgeCode), 4'b0001);
        idle(1);
        check("floor_pulse_end", int'(wallCollision), 0);

        // Left wall, then an empty frame that must hold the code.
        wall_px(0, 281, 200);
        idle(2);
        sof_only();
        check("left_code", int'(HitEdgeCode), 4'b1000);
        idle(4);
        sof_only();
        check("empty_pulse", int'(wallCollision), 0);
        check("empty_hold", int'(HitEdgeCode), 4'b1000);

        // Corner: two edges in one frame are ORed.
        wall_px(0, 281, 200);
        idle(2);
        wall_px(0, 300, 248);
        idle(2);
        sof_only();
        check("corner_code", int'(HitEdgeCode), 4'b1001);
        check("corner_pulse", int'(wallCollision), 1);
        idle(1);

        // Overlap on the boundary cycle belongs to the next frame.
        wall_px(1, 300, 248);
        check("sofpix_not_now", int'(wallCollision), 0);
        idle(3);
        sof_only();
        check("sofpix_next", int'(wallCollision), 1);
        check("sofpix_code", int'(HitEdgeCode), 4'b0001);

        // Back-to-back boundaries.
        wall_px(0, 281, 200);
        sof_only();
        sof_only();
        check("double_sof_pulse", int'(wallCollision), 0);
        check("double_sof_hold", int'(HitEdgeCode), 4'b1000);

        // Ladder only.
        step(0, 0, 300, 200, 280, 185, 1, 0, 1);
        idle(1);
        sof_only();
        check("ladder_lc", int'(ladderCollision), 1);
        check("ladder_wc", int'(wallCollision), 0);
        check("ladder_hold", int'(HitEdgeCode), 4'b1000);

        // Mid-frame reset discards the partial frame.
        wall_px(0, 300, 248);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        sof_only();
        check("rst_mid_wc", int'(wallCollision), 0);
        check("rst_mid_code", int'(HitEdgeCode), 0);

        // Randomized traffic around the sprite box.
        for (int i = 0; i < 4000; i++) begin
            int tlx, tly, px, py;
            bit rst, sof;
            tlx = int'($urandom_range(940)) - 40;
            tly = int'($urandom_range(740)) - 40;
            px  = tlx + int'($urandom_range(79)) - 8;
            py  = tly + int'($urandom_range(79)) - 8;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            rst = ($urandom_range(299) == 0);
            sof = ($urandom_range(15) == 0);
            step(rst, sof, px, py, tlx, tly,
                 $urandom_range(1) == 1, $urandom_range(2) == 0, $urandom_range(2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
